dbg_cmd_framer: RTL and testbench

- Byte-stream front end for the debug module. It sits directly upstream of the debug module and typically connects to a UART or JTAG byte transport.
- Assembles fixed 9-byte command frames from the RX stream and drives cmd/addr/data to the debug module. It holds them stable until the debug module's ready indicates completion.
- Returns a response (status byte plus optional 32-bit read data) on the TX stream.

---
 rtl/dbg_cmd_framer.sv | 151 +++++++++++++++
 tb/tb_dbg_cmd_framer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_framer.sv
// Debug command framer: collects 9-byte command frames from a byte stream, drives them
// to the debug module until it signals ready (or times out), then returns a status/data response.
module dbg_cmd_framer #(
    parameter int          TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  RSP_ERR        = 8'hEE
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  dbg_cmd_o,
    output logic [31:0] dbg_addr_o,
    output logic [31:0] dbg_data_o,
    input  logic [31:0] dbg_data_i,
    input  logic        dbg_ready_i
);

    typedef enum logic [2:0] {
        S_RX_CMD, S_RX_ADDR, S_RX_DATA, S_ISSUE, S_WAIT, S_TX_STAT, S_TX_DATA
    } state_e;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } frame_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    frame_t      dbg_q;
    logic [63:0] shadow_q;
    logic [3:0]  byte_cnt_q;
    logic [15:0] to_cnt_q;
    logic [7:0]  status_q;
    logic [31:0] rsp_q;
    logic        rx_ready_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;

    logic rx_acc, tx_hs, has_data;

    assign rx_acc   = rx_valid_i && rx_ready_q;
    assign tx_hs    = tx_valid_q && tx_ready_i;
    // status_q equals the command echo whenever it is not the error byte
    assign has_data = (status_q != RSP_ERR) &&
                      (status_q == 8'h01 || status_q == 8'h13 || status_q == 8'h15);

    assign rx_ready_o = rx_ready_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign dbg_cmd_o  = dbg_q.cmd;
    assign dbg_addr_o = dbg_q.addr;
    assign dbg_data_o = dbg_q.data;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_RX_CMD;
            dbg_q      <= '0;
            shadow_q   <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            status_q   <= '0;
            rsp_q      <= '0;
            rx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                S_RX_CMD, S_RX_ADDR, S_RX_DATA: begin
                    if (rx_acc) begin
                        shadow_q <= {shadow_q[55:0], rx_data_i};
                        if (byte_cnt_q == 4'd8) begin
                            // Final byte goes straight to the outputs so they are valid during ISSUE
                            dbg_q      <= {shadow_q, rx_data_i};
                            byte_cnt_q <= '0;
                            rx_ready_q <= 1'b0;
                            state_q    <= S_ISSUE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 4'd1;
                            state_q    <= (byte_cnt_q < 4'd4) ? S_RX_ADDR : S_RX_DATA;
                        end
                    end
                end
                S_ISSUE: begin
                    to_cnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (dbg_ready_i) begin
                        rsp_q      <= dbg_data_i;
                        status_q   <= dbg_q.cmd;
                        tx_data_q  <= dbg_q.cmd;
                        tx_valid_q <= 1'b1;
                        dbg_q.cmd  <= 8'h00;
                        to_cnt_q   <= '0;
                        state_q    <= S_TX_STAT;
                    end else if (to_cnt_q == TO_LAST) begin
                        status_q   <= RSP_ERR;
                        tx_data_q  <= RSP_ERR;
                        tx_valid_q <= 1'b1;
                        dbg_q.cmd  <= 8'h00;
                        to_cnt_q   <= '0;
                        state_q    <= S_TX_STAT;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                S_TX_STAT: begin
                    if (tx_hs) begin
                        if (has_data) begin
                            tx_data_q  <= rsp_q[31:24];
                            rsp_q      <= rsp_q << 8;
                            byte_cnt_q <= '0;
                            state_q    <= S_TX_DATA;
                        end else begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= S_RX_CMD;
                        end
                    end
                end
                S_TX_DATA: begin
                    if (tx_hs) begin
                        if (byte_cnt_q == 4'd3) begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            byte_cnt_q <= '0;
                            state_q    <= S_RX_CMD;
                        end else begin
                            tx_data_q  <= rsp_q[31:24];
                            rsp_q      <= rsp_q << 8;
                            byte_cnt_q <= byte_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q    <= S_RX_CMD;
                    rx_ready_q <= 1'b1;
                    tx_valid_q <= 1'b0;
                    byte_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_cmd_framer.sv
// Directed bench for dbg_cmd_framer with a hand-driven debug-module model (TIMEOUT_CYCLES=16).
module tb_dbg_cmd_framer;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;

    int checks = 0;
    int fails  = 0;

    dbg_cmd_framer #(.TIMEOUT_CYCLES(16), .RSP_ERR(8'hEE)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o),
        .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 200) begin step(); n++; end
        if (n >= 200) chk("rx_ready_wait", 32'(n), 32'd0);
        step();
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        logic [71:0] f;
        f = {cmd, addr, data};
        for (int i = 8; i >= 0; i--) send_byte(f[i*8 +: 8]);
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!tx_valid_o && n < 200) begin step(); n++; end
        chk(tag, {24'd0, tx_data_o}, {24'd0, exp});
        tx_ready_i = 1'b1;
        step();
        tx_ready_i = 1'b0;
    endtask

    initial begin
        int n;
        logic stable;
        logic [7:0] exp_b [5];

        rstn_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0; tx_ready_i = 1'b0;
        dbg_data_i = '0; dbg_ready_i = 1'b0;
        #12;
        chk("rst_rx_ready", 32'(rx_ready_o), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_tx_data", 32'(tx_data_o), 32'd0);
        chk("rst_cmd", 32'(dbg_cmd_o), 32'd0);
        chk("rst_addr", dbg_addr_o, 32'd0);
        chk("rst_data", dbg_data_o, 32'd0);
        step();
        rstn_i = 1'b1;
        step();

        // Read mem: 3 WAIT cycles without ready, then DEADBEEF
        send_frame(8'h01, 32'h0000_1000, 32'hA5A5_A5A5);
        chk("rd_issue_cmd", 32'(dbg_cmd_o), 32'h01);
        chk("rd_issue_addr", dbg_addr_o, 32'h0000_1000);
        chk("rd_issue_rx_ready", 32'(rx_ready_o), 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (dbg_cmd_o !== 8'h01 || dbg_addr_o !== 32'h0000_1000) stable = 1'b0;
        end
        step();
        dbg_ready_i = 1'b1; dbg_data_i = 32'hDEAD_BEEF;
        if (dbg_cmd_o !== 8'h01 || dbg_addr_o !== 32'h0000_1000) stable = 1'b0;
        chk("rd_wait_stable", 32'(stable), 32'd1);
        step();
        dbg_ready_i = 1'b0; dbg_data_i = '0;
        chk("rd_cmd_cleared", 32'(dbg_cmd_o), 32'h00);
        chk("rd_addr_held", dbg_addr_o, 32'h0000_1000);
        recv_byte("rd_tx0", 8'h01);
        recv_byte("rd_tx1", 8'hDE);
        recv_byte("rd_tx2", 8'hAD);
        recv_byte("rd_tx3", 8'hBE);
        recv_byte("rd_tx4", 8'hEF);
        chk("rd_done_valid", 32'(tx_valid_o), 32'd0);
        chk("rd_done_rx_ready", 32'(rx_ready_o), 32'd1);

        // Write reg: status only
        send_frame(8'h14, 32'h0000_0005, 32'h1234_5678);
        chk("wr_cmd", 32'(dbg_cmd_o), 32'h14);
        chk("wr_addr", dbg_addr_o, 32'h0000_0005);
        chk("wr_data", dbg_data_o, 32'h1234_5678);
        step(); step(); step();
        dbg_ready_i = 1'b1;
        step();
        dbg_ready_i = 1'b0;
        recv_byte("wr_tx0", 8'h14);
        chk("wr_no_data", 32'(tx_valid_o), 32'd0);

        // Reset command with ready constantly high
        dbg_ready_i = 1'b1;
        send_frame(8'h07, 32'd0, 32'd0);
        chk("rc_issue_cmd", 32'(dbg_cmd_o), 32'h07);
        step();
        chk("rc_wait_cmd", 32'(dbg_cmd_o), 32'h07);
        step();
        chk("rc_cmd_cleared", 32'(dbg_cmd_o), 32'h00);
        dbg_ready_i = 1'b0;
        recv_byte("rc_tx0", 8'h07);
        chk("rc_no_data", 32'(tx_valid_o), 32'd0);

        // Timeout: 16 WAIT cycles then error status
        send_frame(8'h11, 32'h0000_0040, 32'd0);
        chk("to_issue_cmd", 32'(dbg_cmd_o), 32'h11);
        n = 0;
        step();
        while (dbg_cmd_o === 8'h11 && n < 100) begin n++; step(); end
        chk("to_wait_cycles", 32'(n), 32'd16);
        chk("to_cmd_cleared", 32'(dbg_cmd_o), 32'h00);
        recv_byte("to_tx0", 8'hEE);
        chk("to_no_data", 32'(tx_valid_o), 32'd0);

        // TX back-pressure on a read returning CAFEF00D
        send_frame(8'h01, 32'h0000_0020, 32'd0);
        chk("bp_issue_cmd", 32'(dbg_cmd_o), 32'h01);
        step();
        dbg_ready_i = 1'b1; dbg_data_i = 32'hCAFE_F00D;
        step();
        dbg_ready_i = 1'b0; dbg_data_i = '0;
        exp_b[0] = 8'h01; exp_b[1] = 8'hCA; exp_b[2] = 8'hFE; exp_b[3] = 8'hF0; exp_b[4] = 8'h0D;
        for (int k = 0; k < 5; k++) begin
            stable = 1'b1;
            for (int c = 0; c < 5; c++) begin
                if (tx_valid_o !== 1'b1 || tx_data_o !== exp_b[k] || rx_ready_o !== 1'b0) stable = 1'b0;
                step();
            end
            chk($sformatf("bp_hold%0d", k), 32'(stable), 32'd1);
            recv_byte($sformatf("bp_tx%0d", k), exp_b[k]);
        end
        chk("bp_rx_ready_after", 32'(rx_ready_o), 32'd1);

        // Reset mid-frame: partial frame must be discarded
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        rstn_i = 1'b0;
        #2;
        chk("mr_addr_async", dbg_addr_o, 32'd0);
        chk("mr_rx_ready", 32'(rx_ready_o), 32'd1);
        step();
        rstn_i = 1'b1;
        step();
        send_frame(8'h15, 32'd0, 32'd0);
        chk("mr_issue_cmd", 32'(dbg_cmd_o), 32'h15);
        step();
        dbg_ready_i = 1'b1; dbg_data_i = 32'h0000_0100;
        step();
        dbg_ready_i = 1'b0; dbg_data_i = '0;
        recv_byte("mr_tx0", 8'h15);
        recv_byte("mr_tx1", 8'h00);
        recv_byte("mr_tx2", 8'h00);
        recv_byte("mr_tx3", 8'h01);
        recv_byte("mr_tx4", 8'h00);
        chk("mr_done_valid", 32'(tx_valid_o), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
